serial_diff_unit: RTL and testbench
===================================

Name: serial_diff_unit

Overview:
Multi-cycle, bit-serial WIDTH-bit subtractor sitting alongside the combinational difference stage. It computes a - b LSB-first, one bit per clock, through a single full_adder cell (b inverted, initial carry 1). When a < b it runs a second serial pass to produce |a - b|. It provides a start/busy/done handshake so control logic can trade area for latency.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk       input   1      rising-edge clock
reset     input   1      asynchronous, active-high reset
start     input   1      request; sampled only in IDLE
a         input   WIDTH  minuend; captured on the accepting edge
b         input   WIDTH  subtrahend; captured on the accepting edge
busy      output  1      high in SUB and NEG
done      output  1      one-cycle pulse in DONE
diff      output  WIDTH  raw two's-complement a - b (mod 2^WIDTH)
borrow    output  1      1 iff a < b (unsigned)
abs_diff  output  WIDTH  |a - b|

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, including in the middle of an operation.
  - State goes to IDLE.
  - busy, done, diff, borrow, abs_diff and all internal registers are cleared to 0.
- FSM states: IDLE, SUB, NEG, DONE.
- IDLE:
  - When start=1, capture a and b into shift registers, set carry=1 and the bit counter to 0, and go to SUB.
  - When start=0, stay in IDLE.
- SUB (busy=1):
  - Each edge feeds a_sr[0], ~b_sr[0] and carry into full_adder.
  - The sum bit shifts into the MSB of res_sr, and the cell's carry-out is registered as carry.
  - a_sr and b_sr shift right and the counter increments.
  - After the edge that processes bit WIDTH-1:
    - If the final carry-out = 0 (borrow), go to NEG.
    - Otherwise go to DONE.
- NEG (busy=1): serial two's complement of res_sr.
  - Before the pass, copy res_sr to a hidden raw-result register, set carry=1 and counter=0.
  - Each edge feeds ~res_sr[0], 0 and carry into full_adder, and the sum shifts into the MSB.
  - Go to DONE after WIDTH edges.
- Output update: diff, borrow and abs_diff change only on the edge that enters DONE.
  - diff = raw result.
  - borrow = ~final SUB carry.
  - abs_diff = the NEG result if borrow, else the raw result.
  - Outputs hold their previous values throughout SUB and NEG.
- DONE: done=1 for exactly one cycle, busy=0, then unconditionally go to IDLE.
  - A start in DONE is ignored.
  - The earliest next accept is the first IDLE cycle.
- start while busy or in DONE is ignored. Operands are never re-captured mid-operation.
- Latency, with k the accepting edge:
  - No borrow: done is high in the cycle after edge k+WIDTH.
  - Borrow: done is high in the cycle after edge k+2*WIDTH.
- a == b gives diff=0, borrow=0, abs_diff=0, with no NEG pass.
- Wrap-around: diff is modulo 2^WIDTH. The borrow out of the MSB is reported only on borrow.
- Arithmetic reference (bit-exact match required):
  - diff = (a + ~b + 1) mod 2^WIDTH
  - borrow = (a < b)
  - abs_diff = borrow ? (b - a) : (a - b)
- Counter width is $clog2(WIDTH)+1. Terminal compare is against WIDTH-1.

Decomposition:
- Shared package serial_diff_pkg holds:
  - the state encoding constants ST_IDLE, ST_SUB, ST_NEG, ST_DONE (2 bits);
  - the default WIDTH constant.
- One sub-module: the existing full_adder (a, b, cin, sum, cout), instantiated once and muxed between the SUB and NEG operand sources.
- No other hierarchy.

Test Plan:
- Reset, then a=200, b=55, start pulse (WIDTH=8):
  - done after 8 edges;
  - diff=0x91, borrow=0, abs_diff=0x91;
  - busy high for exactly 8 cycles.
- a=55, b=200:
  - done after 16 edges;
  - diff=0x6F, borrow=1, abs_diff=0x91.
- a=0, b=1:
  - diff=0xFF, borrow=1, abs_diff=0x01.
- a=0x80, b=0x80:
  - diff=0, borrow=0, abs_diff=0, done after 8 edges.
- Start a=10, b=3; hold start high and change a/b to 0xFF/0x01 during SUB and DONE:
  - result is diff=0x07;
  - the second request is not accepted until IDLE, and then gives diff=0xFE.
- Assert reset at cycle 5 of a borrow operation:
  - all outputs go to 0 immediately and state is IDLE;
  - a fresh start with a=9, b=4 gives diff=0x05, borrow=0.

Source files
------------

// File: rtl/serial_diff_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_diff_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/serial_diff_if.sv
// Request/result bundle between a controller (master) and the serial subtractor (slave).
interface serial_diff_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] abs_diff;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, abs_diff
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, abs_diff
    );

endinterface

// File: rtl/serial_diff_full_adder.sv
// Single-bit full adder cell shared by the subtract and negate passes.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_diff_unit.sv
// Bit-serial |a - b| unit: one full-adder cell, LSB first, with an optional
// second serial pass that negates the raw result when a < b.
module serial_diff_unit
    import serial_diff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    serial_diff_if.slave bus
);

    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] raw_q, raw_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] abs_q, abs_d;

    logic             fa_a, fa_b, fa_sum, fa_cout;
    logic [WIDTH-1:0] res_shift;

    // The single adder cell computes a + ~b in SUB and ~res + 0 in NEG;
    // both passes start with carry = 1 to complete the two's complement.
    always_comb begin
        if (state_q == ST_NEG) begin
            fa_a = ~res_sr_q[0];
            fa_b = 1'b0;
        end else begin
            fa_a = a_sr_q[0];
            fa_b = ~b_sr_q[0];
        end
    end

    full_adder u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign res_shift = {fa_sum, res_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        raw_d    = raw_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        abs_d    = abs_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    res_sr_d = '0;
                    carry_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SUB;
                end
            end
            ST_SUB: begin
                res_sr_d = res_shift;
                carry_d  = fa_cout;
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    raw_d = res_shift;
                    if (!fa_cout) begin
                        // Borrow: keep the raw result aside and re-arm for negation.
                        carry_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_NEG;
                    end else begin
                        diff_d   = res_shift;
                        borrow_d = 1'b0;
                        abs_d    = res_shift;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_NEG: begin
                res_sr_d = res_shift;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    diff_d   = raw_q;
                    borrow_d = 1'b1;
                    abs_d    = res_shift;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            raw_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            abs_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            raw_q    <= raw_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            abs_q    <= abs_d;
        end
    end

    assign bus.busy     = (state_q == ST_SUB) || (state_q == ST_NEG);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.abs_diff = abs_q;

endmodule

// File: tb/tb_serial_diff_unit.sv
// Directed bench for serial_diff_unit with a cycle-level transaction model and literal checks.
module tb_serial_diff_unit;

    localparam int W = 8;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    serial_diff_if #(.WIDTH(W)) bus ();

    serial_diff_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted request keeps the unit busy for W cycles
    // (2W when a < b), then shows one done cycle with the arithmetic result.
    int         m_rem    = 0;
    logic       m_done   = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic       m_borrow = 1'b0;
    logic [W-1:0] m_abs  = '0;
    logic [W-1:0] p_diff = '0;
    logic       p_borrow = 1'b0;
    logic [W-1:0] p_abs  = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem    <= 0;
            m_done   <= 1'b0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_abs    <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_done   <= 1'b1;
                m_diff   <= p_diff;
                m_borrow <= p_borrow;
                m_abs    <= p_abs;
            end
        end else if (bus.start) begin
            p_diff   <= bus.a - bus.b;
            p_borrow <= (bus.a < bus.b);
            p_abs    <= (bus.a < bus.b) ? (bus.b - bus.a) : (bus.a - bus.b);
            m_rem    <= (bus.a < bus.b) ? 2 * W : W;
        end
    end

    always @(negedge clk) begin
        check("m_busy",   {31'd0, bus.busy},   {31'd0, m_rem > 0});
        check("m_done",   {31'd0, bus.done},   {31'd0, m_done});
        check("m_diff",   {24'd0, bus.diff},   {24'd0, m_diff});
        check("m_borrow", {31'd0, bus.borrow}, {31'd0, m_borrow});
        check("m_abs",    {24'd0, bus.abs_diff}, {24'd0, m_abs});
    end

    task automatic wait_done(input string tag, input int elat, input int ebusy);
        int edges;
        int busy_n;
        edges  = 0;
        busy_n = 0;
        while (!bus.done && edges < 40) begin
            if (bus.busy) busy_n++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_lat"},  edges,  elat);
        check({tag, "_busy"}, busy_n, ebusy);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input logic [W-1:0] ea,
                          input int elat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tag, elat, elat);
        check({tag, "_diff"},   {24'd0, bus.diff},     {24'd0, ed});
        check({tag, "_borrow"}, {31'd0, bus.borrow},   {31'd0, eb});
        check({tag, "_abs"},    {24'd0, bus.abs_diff}, {24'd0, ea});
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_diff", {24'd0, bus.diff}, 32'd0);
        reset = 1'b0;

        run_op("t200_55", 8'd200, 8'd55,  8'h91, 1'b0, 8'h91, 8);
        run_op("t55_200", 8'd55,  8'd200, 8'h6F, 1'b1, 8'h91, 16);
        run_op("t0_1",    8'd0,   8'd1,   8'hFF, 1'b1, 8'h01, 16);
        run_op("t80_80",  8'h80,  8'h80,  8'h00, 1'b0, 8'h00, 8);

        // Held start with operands changing mid-operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd10;
        bus.b     = 8'd3;
        @(posedge clk);
        @(negedge clk);
        bus.a = 8'hFF;
        bus.b = 8'h01;
        wait_done("hold1", 8, 8);
        check("hold1_diff", {24'd0, bus.diff}, 32'h07);
        @(posedge clk);
        @(negedge clk);
        check("hold_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("hold_idle_done", {31'd0, bus.done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("hold2_busy", {31'd0, bus.busy}, 32'd1);
        wait_done("hold2", 8, 8);
        check("hold2_diff",   {24'd0, bus.diff},     32'hFE);
        check("hold2_borrow", {31'd0, bus.borrow},   32'd0);
        check("hold2_abs",    {24'd0, bus.abs_diff}, 32'hFE);

        // Asynchronous reset in the middle of a borrow operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd55;
        bus.b     = 8'd200;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("ar_busy",   {31'd0, bus.busy},     32'd0);
        check("ar_done",   {31'd0, bus.done},     32'd0);
        check("ar_diff",   {24'd0, bus.diff},     32'd0);
        check("ar_borrow", {31'd0, bus.borrow},   32'd0);
        check("ar_abs",    {24'd0, bus.abs_diff}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("t9_4", 8'd9, 8'd4, 8'h05, 1'b0, 8'h05, 8);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
